// File: rtl/ss_pkg.sv
// Shared glyph definitions for the 7-segment display path: code width,
// named glyph codes and the scroller state encoding.
package ss_pkg;

  localparam int CODE_W = 5;

  typedef logic [CODE_W-1:0] glyph_t;

  localparam glyph_t CODE_SPACE = 5'd30;

  localparam glyph_t G_H     = 5'd16;
  localparam glyph_t G_PI    = 5'd17;
  localparam glyph_t G_U     = 5'd18;
  localparam glyph_t G_N     = 5'd19;
  localparam glyph_t G_GAMMA = 5'd20;
  localparam glyph_t G_P     = 5'd21;
  localparam glyph_t G_L     = 5'd22;
  localparam glyph_t G_G     = 5'd23;
  localparam glyph_t G_Y     = 5'd24;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } scroll_state_t;

endpackage

// File: rtl/ss_scroll_mux_tick_div.sv
// Free-running modulo-DIV counter; tick_o is high during the terminal count
// cycle so the consumer advances on the same edge the counter wraps.
module tick_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick_o = en && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ss_scroll_mux.sv
// Message buffer plus multiplexed-digit scanner that scrolls the message
// right-to-left; feeds the glyph decoder one code per scan slot.
module ss_scroll_mux
  import ss_pkg::*;
#(
  parameter int N_DIGITS   = 4,
  parameter int MSG_LEN    = 16,
  parameter int SCAN_DIV   = 50000,
  parameter int SCROLL_DIV = 25
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
  input  logic [CODE_W-1:0]          wr_data,
  input  logic [$clog2(MSG_LEN):0]   len_i,
  input  logic                       start_i,
  input  logic                       stop_i,
  input  logic                       scroll_en,
  output logic [CODE_W-1:0]          code_o,
  output logic [N_DIGITS-1:0]        dig_sel_o,
  output logic                       wrap_o
);

  localparam int AW = $clog2(MSG_LEN);
  localparam int DW = $clog2(N_DIGITS);
  localparam int PW = AW + 2;
  localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  localparam logic [DW-1:0] DIG_LAST    = DW'(N_DIGITS - 1);
  localparam logic [SW-1:0] SCROLL_LAST = SW'(SCROLL_DIV - 1);
  localparam logic [AW:0]   LEN_MAX     = (AW + 1)'(MSG_LEN);
  localparam logic [PW-1:0] N_DIG_P     = PW'(N_DIGITS);

  scroll_state_t state, state_next;

  logic          scan_tick;
  logic          frame_tick;
  logic          count_en;
  logic          blank_all;
  logic          step;
  logic          at_top;
  logic [DW-1:0] dig;
  logic [AW:0]   len_q;
  logic [PW-1:0] pos;
  logic [PW-1:0] pos_top;
  logic [PW-1:0] slot_pos;
  logic [PW-1:0] idx;
  logic [SW-1:0] scroll_cnt;
  glyph_t        glyph;
  glyph_t        msg_mem [MSG_LEN];

  tick_div #(.DIV(SCAN_DIV)) u_scan_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (1'b1),
    .tick_o (scan_tick)
  );

  assign frame_tick = scan_tick && (dig == DIG_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig <= '0;
    end else if (scan_tick) begin
      dig <= (dig == DIG_LAST) ? '0 : dig + 1'b1;
    end
  end

  // NOTE: the message store has no reset; its contents are only meaningful
  // after software writes them, and a reset would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      msg_mem[wr_addr] <= wr_data;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM: next state (start beats stop; stop is ignored while idle)
  always_comb begin
    state_next = state;
    if (start_i) begin
      state_next = scroll_en ? RUN : HOLD;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        RUN:     if (stop_i) state_next = IDLE; else if (!scroll_en) state_next = HOLD;
        HOLD:    if (stop_i) state_next = IDLE; else if (scroll_en) state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    blank_all = 1'b0;
    count_en  = 1'b0;
    case (state)
      IDLE:    blank_all = 1'b1;
      RUN:     count_en  = scroll_en && !start_i && !stop_i;
      default: count_en  = 1'b0;
    endcase
  end

  assign pos_top = PW'(len_q) + PW'(N_DIGITS - 1);
  assign at_top  = (pos == pos_top);
  assign step    = count_en && frame_tick && (scroll_cnt == SCROLL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      pos        <= '0;
      scroll_cnt <= '0;
      wrap_o     <= 1'b0;
    end else begin
      wrap_o <= step && at_top;
      if (start_i) begin
        len_q      <= (len_i > LEN_MAX) ? LEN_MAX : len_i;
        pos        <= '0;
        scroll_cnt <= '0;
      end else if (stop_i && (state != IDLE)) begin
        pos        <= '0;
        scroll_cnt <= '0;
      end else if (count_en && frame_tick) begin
        if (step) begin
          scroll_cnt <= '0;
          pos        <= at_top ? '0 : pos + 1'b1;
        end else begin
          scroll_cnt <= scroll_cnt + 1'b1;
        end
      end
    end
  end

  // Digit d shows message index pos+d-N_DIGITS; anything outside the
  // message is blank, which gives the scroll-in and scroll-out margins.
  always_comb begin
    glyph    = CODE_SPACE;
    slot_pos = pos + PW'(dig);
    idx      = slot_pos - N_DIG_P;
    if ((slot_pos >= N_DIG_P) && (idx < PW'(len_q))) begin
      glyph = msg_mem[idx[AW-1:0]];
    end
  end

  // Code and select are registered from the same dig value so they switch
  // on the same edge and never ghost onto a neighbouring digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_o    <= CODE_SPACE;
      dig_sel_o <= '0;
    end else begin
      code_o    <= blank_all ? CODE_SPACE : glyph;
      dig_sel_o <= N_DIGITS'(1) << dig;
    end
  end

endmodule

// File: doc/ss_scroll_mux.md
Name: ss_scroll_mux

Overview:
- Upstream neighbour of the 7-segment glyph decoder: holds a message of 5-bit glyph codes and scrolls it right-to-left across N_DIGITS multiplexed digits.
- Each scan slot drives one 5-bit code (feeds the decoder's code input) plus a one-hot digit select.
- Codes 0-15 are hex digits, 16-24 are letters, 30 is blank/space.

Parameters:
- N_DIGITS, 4, number of physical digits (2..8).
- MSG_LEN, 16, message buffer depth in codes (power of two, >= N_DIGITS).
- SCAN_DIV, 50000, clk cycles per digit scan slot (>= 2).
- SCROLL_DIV, 25, complete scan frames per one-position scroll step (>= 1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  AW=$clog2(MSG_LEN)  write address.
- wr_data  in  5  glyph code to write.
- len_i  in  AW+1  message length, latched on start_i.
- start_i  in  1  single-cycle pulse: (re)start scrolling from position 0.
- stop_i  in  1  single-cycle pulse: return to IDLE.
- scroll_en  in  1  1 = advance scroll; 0 = freeze position (scan continues).
- code_o  out  5  code for the currently selected digit.
- dig_sel_o  out  N_DIGITS  one-hot active-high; bit d = digit d, d=0 leftmost.
- wrap_o  out  1  one-cycle pulse when the scroll position wraps to 0.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: code_o=5'd30, dig_sel_o=0, wrap_o=0.
  - State: state=IDLE, pos=0, dig=0, len_q=0, prescalers=0.
  - The buffer is not reset.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 in every state except reset; the terminal count produces scan_tick.
  - On scan_tick, dig advances 0..N_DIGITS-1 and wraps. A wrap from N_DIGITS-1 to 0 is frame_tick.
- Output latency: code_o and dig_sel_o are registered and change together exactly 1 clk after dig changes, so there is no ghosting between code and select.
- Glyph selection: for digit d, idx = pos + d - N_DIGITS. If idx < 0 or idx >= len_q, the code is 30; otherwise it is buf[idx].
- Write path:
  - Writes are accepted in any state.
  - A write to the address being read in the same cycle returns the old data (read-before-write).
  - The new data is visible from the next read.
- FSM:
  - IDLE: dig_sel_o still scans; code_o is forced to 30. start_i -> RUN.
  - RUN: scroll counter counts frame_ticks while scroll_en=1. After SCROLL_DIV frames, pos advances at a frame boundary only. scroll_en=0 -> HOLD.
  - HOLD: pos and scroll counter frozen. scroll_en=1 -> RUN, with the count resumed rather than cleared.
  - stop_i in RUN or HOLD -> IDLE, pos=0.
  - start_i in any state: latch len_q, set pos=0, clear the scroll counter, go to RUN (or to HOLD if scroll_en=0).
  - start_i and stop_i in the same cycle: start_i wins.
- Length:
  - len_q = min(len_i, MSG_LEN).
  - pos range is 0..len_q+N_DIGITS-1. Stepping past the top sets pos=0 and pulses wrap_o for 1 cycle.
  - len_q=0 gives all blanks, and wrap_o fires every N_DIGITS steps.
- Mid-operation reset: outputs return to reset values immediately, with no waiting for a clock edge.

Decomposition:
- Shared package ss_pkg:
  - CODE_W=5.
  - CODE_SPACE=5'd30.
  - Named glyph constants (G_H=16, G_PI=17, G_U=18, G_N=19, G_GAMMA=20, G_P=21, G_L=22, G_G=23, G_Y=24).
  - typedef logic [CODE_W-1:0] glyph_t.
  - enum scroll_state_t {IDLE, RUN, HOLD}.
- Sub-module tick_div: parameter DIV. Ports clk, rst_n, en, tick_o. Instantiated for the scan prescaler. The scroll divider is a plain counter on frame_tick.

Test Plan (N_DIGITS=4, MSG_LEN=16, SCAN_DIV=2, SCROLL_DIV=1):
- Scan timing: after reset release, dig_sel_o steps 0001,0010,0100,1000,0001. Each value is held 2 clk. code_o=30 throughout while in IDLE.
- Scroll-in:
  - Stimulus: write 16,14,22,22,0 at addresses 0..4; len_i=5; start_i.
  - pos=0: frame shows 30,30,30,30.
  - pos=1: digit3=16, others 30.
  - pos=4: digits show 16,14,22,22.
- Wrap:
  - Same message; pos=8 shows 0,30,30,30.
  - The next step sets pos=0 with exactly one wrap_o pulse. The full cycle is 9 positions.
- Hold/stop:
  - scroll_en=0 for 10 frames: pos unchanged, dig_sel_o keeps scanning. Re-raise: scrolling resumes.
  - stop_i: code_o=30 from the next slot.
- Boundaries:
  - len_i=20 clamps to 16.
  - len_i=0 gives all 30 and wrap_o every 4 steps.
  - start_i together with stop_i enters RUN.
  - A write to the address currently displayed appears in the next frame.
- Async reset: rst_n low mid-RUN. Without a clk edge, code_o=30, dig_sel_o=0 and wrap_o=0. After release the block is in IDLE with pos=0.
